// File: rtl/delta_stress_monitor.sv
// Heart-rate delta/stress monitor: the baseline is latched from a stable sample window, and a sustained rise above it raises an alarm.
// Optional hysteresis on alarm exit is enabled by defining DSM_HYST_EN.
module delta_stress_monitor #(
  parameter int W       = 6,
  parameter int DEPTH   = 3,
  parameter int TOL     = 0,
  parameter int DELTA   = 1,
  parameter int ALARM_N = 4
) (
  input  logic         slow,
  input  logic         reset,
  input  logic         sample_en,
  input  logic [W-1:0] hart,
  output logic         stable,
  output logic         lower,
  output logic         higher,
  output logic         alarm,
  output logic [W-1:0] baseline
);

  typedef enum logic [1:0] {INIT, TRACK, ALARM} state_e;

  localparam int            FW      = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] DEPTH_V = FW'(DEPTH);
  localparam logic [W:0]    TOL_V   = (W + 1)'(TOL);
  localparam logic [W:0]    DELTA_V = (W + 1)'(DELTA);
  localparam logic [3:0]    ALARM_V = 4'(ALARM_N);

  logic [W-1:0]  hist_q [DEPTH];
  logic [W-1:0]  hist_d [DEPTH];
  logic [FW-1:0] fill_q, fill_d;
  logic          stable_q, stable_d;
  logic          rise_q;
  logic [W-1:0]  base_q;
  logic [3:0]    hi_cnt_q, hi_cnt_d;
  state_e        state_q;
  logic          alarm_q;
  logic          tracking;

  // Magnitude of an unsigned difference, one bit wider so it can never wrap.
  function automatic logic [W:0] absDiff(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (sample_en) begin
      hist_d[0] = hart;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      if (fill_q != DEPTH_V) fill_d = fill_q + FW'(1);
    end
  end

  // Stability is judged on the post-shift window so it settles one cycle after the sample.
  always_comb begin
    stable_d = (fill_d == DEPTH_V);
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (absDiff(hist_d[i], hist_d[i+1]) > TOL_V) stable_d = 1'b0;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_q   <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) base_q <= '1;
    else if (rise_q) base_q <= hist_q[0];
  end

  assign tracking = (state_q != INIT);
  assign lower    = tracking && (base_q >= hart) && (absDiff(base_q, hart) >= DELTA_V);
  assign higher   = tracking && (hart >= base_q) && (absDiff(base_q, hart) >= DELTA_V);

  // A baseline latch restarts the rise count even if this cycle carries a higher sample.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    if (rise_q) hi_cnt_d = '0;
    else if (sample_en) begin
      if (!higher) hi_cnt_d = '0;
      else if (hi_cnt_q != ALARM_V) hi_cnt_d = hi_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) hi_cnt_q <= '0;
    else hi_cnt_q <= hi_cnt_d;
  end

`ifdef DSM_HYST_EN
  logic [3:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (sample_en) begin
      if (higher) clr_cnt_d = '0;
      else if (clr_cnt_q != ALARM_V) clr_cnt_d = clr_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) clr_cnt_q <= '0;
    else clr_cnt_q <= clr_cnt_d;
  end

  logic alarm_exit;
  assign alarm_exit = sample_en && !higher && (clr_cnt_d == ALARM_V);
`else
  logic alarm_exit;
  assign alarm_exit = sample_en && !higher;
`endif

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          alarm_q <= 1'b0;
          if (rise_q) state_q <= TRACK;
        end
        TRACK: begin
          if (hi_cnt_d == ALARM_V) begin
            state_q <= ALARM;
            alarm_q <= 1'b1;
          end
        end
        ALARM: begin
          if (alarm_exit) begin
            state_q <= TRACK;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign stable   = stable_q;
  assign baseline = base_q;
  assign alarm    = alarm_q;

endmodule

// File: doc/delta_stress_monitor.md
DELTA_STRESS_MONITOR -- requirements
Module: delta_stress_monitor

Interface
REQ-001 SHALL have parameter W, default 6: heart-rate sample width in bits, legal range 4..12.
REQ-002 SHALL have parameter DEPTH, default 3: number of past samples compared for stability, legal range 2..8.
REQ-003 SHALL have parameter TOL, default 0: maximum absolute difference between samples still counted as equal.
REQ-004 SHALL have parameter DELTA, default 1: minimum deviation from baseline that counts as lower or higher.
REQ-005 SHALL have parameter ALARM_N, default 4: consecutive higher samples needed to raise an alarm, legal range 1..15.
REQ-006 SHALL have port slow, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port sample_en, input, 1 bit: qualifies hart for one cycle.
REQ-009 SHALL have port hart, input, W bits: heart-rate sample.
REQ-010 SHALL have port stable, output, 1 bit: the window is stable.
REQ-011 SHALL have port lower, output, 1 bit: current sample is below baseline by at least DELTA.
REQ-012 SHALL have port higher, output, 1 bit: current sample is above baseline by at least DELTA.
REQ-013 SHALL have port alarm, output, 1 bit: sustained rise above baseline.
REQ-014 SHALL have port baseline, output, W bits: latched reference value.

Function
REQ-015 SHALL keep a history of DEPTH registered samples, shifting only on cycles with sample_en=1; hart is ignored when sample_en=0.
REQ-016 SHALL register stable; it is 1 when the history is full and every adjacent pair of history entries differs by at most TOL. All compares SHALL be unsigned.
REQ-017 SHALL update stable one cycle after the qualifying sample_en.
REQ-018 SHALL latch baseline from the newest history entry on the cycle after stable rises 0->1; it SHALL hold baseline while stable stays high and after stable falls.
REQ-019 SHALL compute lower = (baseline - hart) >= DELTA and higher = (hart - baseline) >= DELTA, both combinational from hart and baseline; differences SHALL be evaluated in W+1 bits with no wrap.
REQ-020 SHALL run a state machine with states INIT, TRACK and ALARM.
- INIT -> TRACK on the first baseline latch.
- TRACK -> ALARM when the higher-sample counter reaches ALARM_N.
- ALARM -> TRACK on a sample_en with higher=0.
REQ-021 SHALL run a higher-sample counter: +1 on each sample_en with higher=1, cleared on any sample_en with higher=0, saturating at ALARM_N.
REQ-022 SHALL clear the higher-sample counter on a baseline latch; a latch in the same cycle as a counter increment SHALL take priority.
REQ-023 SHALL force lower, higher and alarm to 0 in INIT.
REQ-024 SHALL drive alarm high only in the ALARM state; it is registered.
REQ-025 SHALL make the history "full" only after DEPTH qualified samples following reset.

Reset
REQ-026 SHALL, on reset, asynchronously set: history empty, stable=0, baseline=2^W-1 (63 at default), counter=0, state=INIT, alarm=0.
REQ-027 SHALL abandon any in-progress window or count when reset is asserted mid-operation; no partial state SHALL survive.

Configuration
REQ-028 SHALL, when DSM_HYST_EN is defined, make ALARM exit only after ALARM_N consecutive sample_en with higher=0, counted by a separate clear counter that is reset on any higher=1.
REQ-029 SHALL, when DSM_HYST_EN is undefined, exit ALARM on the first sample_en with higher=0 (REQ-020); the clear counter SHALL not be instantiated.

Verification
REQ-030 SHALL cover: reset, then 3x sample 40 -> stable=1 one cycle after the 3rd sample, baseline=40 the next cycle, state TRACK.
REQ-031 SHALL cover: baseline 40, samples 41,41,41,41 -> higher=1 each, alarm=1 after the 4th.
REQ-032 SHALL cover: in ALARM, one sample 40 -> alarm=0 without DSM_HYST_EN; with it, alarm stays 1 until 4 non-higher samples.
REQ-033 SHALL cover: samples 40,41,40 with TOL=0 -> stable=0; with TOL=1 -> stable=1.
REQ-034 SHALL cover: W=6, baseline 0, hart 63; then baseline 63, hart 0 -> higher=1 then lower=1, no wrap.
REQ-035 SHALL cover: reset asserted after 2 of 4 higher samples -> baseline=63, counter=0, state INIT, alarm=0 immediately.
